// File: rtl/spi_rom_responder.sv
// Instruction-fetch byte reader: issues READ (cmd + 24-bit addr) to a mode-0 SPI NOR flash.
// Optional single-entry last-address cache enabled by defining SPI_ROM_CACHE_EN.
module spi_rom_responder #(
  parameter int          ADDR_W   = 16,
  parameter int          CLK_DIV  = 2,
  parameter logic [7:0]  READ_CMD = 8'h03
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  output logic [7:0]        rdata,
  output logic              ready,
  output logic              busy,
  output logic              spi_cs_n,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [39:0]      shift_q, shift_d;
  logic [5:0]       bit_q, bit_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       data_q, data_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             cs_n_q, cs_n_d;
  logic             sclk_q, sclk_d;
  logic             hit;

`ifdef SPI_ROM_CACHE_EN
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] tag_q, tag_d;
  logic [7:0]        cdata_q, cdata_d;
  logic              cvalid_q, cvalid_d;

  assign hit = cvalid_q && (addr == tag_q);
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    div_d   = div_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    busy_d  = busy_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
`ifdef SPI_ROM_CACHE_EN
    addr_d   = addr_q;
    tag_d    = tag_q;
    cdata_d  = cdata_q;
    cvalid_d = cvalid_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        shift_d = '0;
        if (req && hit) begin
          // Cache hit: complete next cycle without touching the SPI pins.
          state_d = ST_DONE;
          ready_d = 1'b1;
`ifdef SPI_ROM_CACHE_EN
          rdata_d = cdata_q;
`endif
        end else if (req) begin
          state_d = ST_SHIFT;
          busy_d  = 1'b1;
          cs_n_d  = 1'b0;
          shift_d = {READ_CMD, 24'(addr), 8'h00};
          bit_d   = 6'd39;
          div_d   = '0;
`ifdef SPI_ROM_CACHE_EN
          addr_d  = addr;
`endif
        end
      end

      ST_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            data_d = {data_q[6:0], spi_miso};
          end else if (bit_q == 6'd0) begin
            // Final falling edge doubles as DONE entry.
            state_d = ST_DONE;
            busy_d  = 1'b0;
            cs_n_d  = 1'b1;
            shift_d = '0;
            ready_d = 1'b1;
            rdata_d = data_q;
`ifdef SPI_ROM_CACHE_EN
            tag_d    = addr_q;
            cdata_d  = data_q;
            cvalid_d = 1'b1;
`endif
          end else begin
            bit_d   = bit_q - 6'd1;
            shift_d = {shift_q[38:0], 1'b0};
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
    end
  end

`ifdef SPI_ROM_CACHE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      tag_q    <= '0;
      cdata_q  <= '0;
      cvalid_q <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      tag_q    <= tag_d;
      cdata_q  <= cdata_d;
      cvalid_q <= cvalid_d;
    end
  end
`endif

  assign rdata    = rdata_q;
  assign ready    = ready_q;
  assign busy     = busy_q;
  assign spi_cs_n = cs_n_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = shift_q[39];

endmodule

// File: tb/tb_spi_rom_responder.sv
// Bench for spi_rom_responder: two instances (CLK_DIV=2 and 1) with a behavioural SPI flash model and scoreboard.
module tb_spi_rom_responder;

  typedef struct { int dut; logic [7:0] data; int due; } sb_t;
  typedef struct { int dut; logic [39:0] bits; } fr_t;
  typedef struct { logic [15:0] addr; logic hit; logic [7:0] data; } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       req [2];
  logic [15:0] addr [2];
  logic [7:0] rdata [2];
  logic       ready [2];
  logic       busy [2];
  logic       cs_n [2];
  logic       sclk [2];
  logic       mosi [2];
  logic       miso [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int aborts = 0;
  int div_tab [2] = '{2, 1};
  bit cache_on;

  sb_t sb_q [$];
  fr_t fr_q [$];
  vec_t vecs [5];

  // flash model state
  logic [39:0] fr_sh [2];
  int          fr_cnt [2];
  logic        fr_act [2];
  logic [15:0] fl_addr [2];
  int          last_rise [2];
  logic        tim_bad [2];
  logic        sclk_prev [2];
  logic        mosi_prev [2];
  logic [7:0]  fb;

  spi_rom_responder #(.ADDR_W(16), .CLK_DIV(2), .READ_CMD(8'h03)) dut0 (
    .clk(clk), .rst(rst), .req(req[0]), .addr(addr[0]), .rdata(rdata[0]),
    .ready(ready[0]), .busy(busy[0]), .spi_cs_n(cs_n[0]), .spi_sclk(sclk[0]),
    .spi_mosi(mosi[0]), .spi_miso(miso[0]));

  spi_rom_responder #(.ADDR_W(16), .CLK_DIV(1), .READ_CMD(8'h03)) dut1 (
    .clk(clk), .rst(rst), .req(req[1]), .addr(addr[1]), .rdata(rdata[1]),
    .ready(ready[1]), .busy(busy[1]), .spi_cs_n(cs_n[1]), .spi_sclk(sclk[1]),
    .spi_mosi(mosi[1]), .spi_miso(miso[1]));

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mem(input logic [15:0] a);
    case (a)
      16'h1234: return 8'hA5;
      16'h0000: return 8'h11;
      16'h0001: return 8'h22;
      default:  return a[7:0] ^ a[15:8] ^ 8'h3C;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Flash model and scoreboard consumer, sampled on the falling clk edge.
  initial begin
    for (int i = 0; i < 2; i++) begin
      miso[i] = 1'b0; fr_act[i] = 1'b0; fr_cnt[i] = 0; fr_sh[i] = '0;
      sclk_prev[i] = 1'b0; mosi_prev[i] = 1'b0; tim_bad[i] = 1'b0;
      last_rise[i] = -1; fl_addr[i] = '0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!cs_n[i]) begin
          if (!fr_act[i]) begin
            fr_act[i] = 1'b1; fr_cnt[i] = 0; fr_sh[i] = '0;
            last_rise[i] = -1; tim_bad[i] = 1'b0;
          end
          if (sclk[i] && !sclk_prev[i]) begin
            fr_sh[i] = {fr_sh[i][38:0], mosi[i]};
            if (last_rise[i] >= 0 && (cyc - last_rise[i]) != 2 * div_tab[i]) tim_bad[i] = 1'b1;
            last_rise[i] = cyc;
            fr_cnt[i]++;
            if (fr_cnt[i] == 32) fl_addr[i] = fr_sh[i][15:0];
          end
          if (sclk[i] && (mosi[i] != mosi_prev[i])) tim_bad[i] = 1'b1;
          if (fr_cnt[i] >= 32 && fr_cnt[i] < 40) begin
            fb = mem(fl_addr[i]);
            miso[i] = fb[39 - fr_cnt[i]];
          end else begin
            miso[i] = 1'b0;
          end
        end else begin
          miso[i] = 1'b0;
          if (fr_act[i]) begin
            fr_act[i] = 1'b0;
            if (fr_cnt[i] == 40) begin
              $display("frame dut%0d mosi=%h cyc=%0d", i, fr_sh[i], cyc);
              if (fr_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_frame dut%0d: got %h required none", i, fr_sh[i]);
              end else begin
                fr_t f;
                f = fr_q.pop_front();
                check("frame_dut", 64'(i), 64'(f.dut));
                check("mosi_frame", 64'(fr_sh[i]), 64'(f.bits));
                check("sclk_mosi_timing", 64'(tim_bad[i]), 64'(0));
              end
            end else begin
              aborts++;
              $display("aborted frame dut%0d after %0d bits cyc=%0d", i, fr_cnt[i], cyc);
            end
          end
        end
        sclk_prev[i] = sclk[i];
        mosi_prev[i] = mosi[i];

        if (ready[i]) begin
          $display("ready dut%0d rdata=%h cyc=%0d", i, rdata[i], cyc);
          if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ready dut%0d: got rdata %h required no pulse", i, rdata[i]);
          end else begin
            sb_t e;
            e = sb_q.pop_front();
            check("ready_dut", 64'(i), 64'(e.dut));
            check("rdata", 64'(rdata[i]), 64'(e.data));
            check("ready_cycle", 64'(cyc), 64'(e.due));
            check("done_pins", 64'({cs_n[i], sclk[i], busy[i]}), 64'(3'b100));
          end
        end
      end
    end
  end

  task automatic push_exp(input int i, input logic [15:0] a, input logic [7:0] d,
                          input int due, input bit spi);
    sb_t e;
    fr_t f;
    e.dut = i; e.data = d; e.due = due;
    sb_q.push_back(e);
    if (spi) begin
      f.dut = i; f.bits = {8'h03, 8'h00, a, 8'h00};
      fr_q.push_back(f);
    end
  endtask

  task automatic start_req(input int i, input logic [15:0] a, input logic [7:0] d, input logic hit);
    bit h;
    h = cache_on && hit;
    addr[i] = a;
    req[i]  = 1'b1;
    $display("req dut%0d addr=%h cyc=%0d expect=%h hit=%0d", i, a, cyc, d, h);
    push_exp(i, a, d, h ? cyc + 1 : cyc + 80 * div_tab[i] + 1, !h);
  endtask

  task automatic wait_ready(input int i);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      seen = ready[i];
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL ready_timeout dut%0d: got no ready in 400 cycles, required a pulse", i);
    end
  endtask

  task automatic fetch(input int i, input logic [15:0] a, input logic [7:0] d, input logic hit);
    @(negedge clk);
    start_req(i, a, d, hit);
    wait_ready(i);
    req[i] = 1'b0;
  endtask

  initial begin
    int c;
`ifdef SPI_ROM_CACHE_EN
    cache_on = 1'b1;
`else
    cache_on = 1'b0;
`endif
    vecs[0] = '{16'h1234, 1'b0, 8'hA5};
    vecs[1] = '{16'h1234, 1'b1, 8'hA5};
    vecs[2] = '{16'h00FF, 1'b0, 8'hC3};
    vecs[3] = '{16'h00FF, 1'b1, 8'hC3};
    vecs[4] = '{16'h1234, 1'b0, 8'hA5};

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; addr[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset_pins", 64'({cs_n[i], sclk[i], mosi[i], ready[i], busy[i]}), 64'(5'b10000));
      check("reset_rdata", 64'(rdata[i]), 64'(0));
    end
    rst = 1'b0;

    // Single fetches and cache repeats
    for (int v = 0; v < 5; v++) fetch(0, vecs[v].addr, vecs[v].data, vecs[v].hit);

    // Back-to-back with req held across DONE
    @(negedge clk);
    c = cyc;
    start_req(0, 16'h0000, 8'h11, 1'b0);
    push_exp(0, 16'h0001, 8'h22, c + 322, 1'b1);
    wait_ready(0);
    addr[0] = 16'h0001;
    @(negedge clk);
    check("b2b_cs_gap", 64'({cs_n[0], busy[0]}), 64'(2'b01));
    req[0] = 1'b0;
    wait_ready(0);

    // Request while busy is dropped
    @(negedge clk);
    c = cyc;
    start_req(0, 16'h0000, 8'h11, 1'b0);
    @(negedge clk);
    req[0] = 1'b0;
    while (cyc < c + 21) @(negedge clk);
    req[0] = 1'b1; addr[0] = 16'hBEEF;
    @(negedge clk);
    req[0] = 1'b0; addr[0] = 16'h0000;
    wait_ready(0);

    // Divider 1
    fetch(1, 16'hFFFF, 8'h3C, 1'b0);

    // Reset mid-transfer
    @(negedge clk);
    c = cyc;
    addr[0] = 16'h5555; req[0] = 1'b1;
    $display("req dut0 addr=5555 cyc=%0d (to be aborted)", cyc);
    @(negedge clk);
    req[0] = 1'b0;
    while (cyc < c + 51) @(negedge clk);
    check("mid_busy", 64'({busy[0], cs_n[0]}), 64'(2'b10));
    #2 rst = 1'b1;
    #1;
    check("abort_pins", 64'({cs_n[0], sclk[0], mosi[0], busy[0], ready[0]}), 64'(5'b10000));
    check("abort_rdata", 64'(rdata[0]), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_count", 64'(aborts), 64'(1));
    fetch(0, 16'h1234, 8'hA5, 1'b0);

    repeat (20) @(negedge clk);
    check("sb_drained", 64'(sb_q.size()), 64'(0));
    check("frames_drained", 64'(fr_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_rom_responder.md
# spi_rom_responder

Program-memory responder for the 8-bit computer's instruction fetch path. It accepts a byte-read request with a 16-bit address from the core's fetch logic and services it from an external SPI NOR flash using the standard READ command (0x03, 24-bit address, mode 0). It returns the byte with a one-cycle `ready` strobe. It sits between the core's program counter/ROM-output path and the SPI pins on the bidirectional IO header.

## Interface
Parameters:
- `ADDR_W`, 16: width of the request address. It is zero-extended to the 24-bit flash address.
- `CLK_DIV`, 2: SCLK half-period in `clk` cycles. Legal range is ≥1.
- `READ_CMD`, 8'h03: command byte sent first, MSB first.

Ports:
- `clk`  in  1: system clock. All state changes on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req`  in  1: fetch request. Sampled only while `busy`=0.
- `addr`  in  ADDR_W: byte address. Latched on the accepting edge.
- `rdata`  out  8: last fetched byte. Holds until the next completion.
- `ready`  out  1: one-cycle pulse. `rdata` is valid in the same cycle.
- `busy`  out  1: high while a transfer is in progress.
- `spi_cs_n`  out  1: flash chip select, active low.
- `spi_sclk`  out  1: SPI clock, idle low (mode 0).
- `spi_mosi`  out  1: command and address bits.
- `spi_miso`  in  1: data from the flash.

## Operation
- States and transitions:
  - IDLE → SHIFT, on `req` with `busy`=0.
  - SHIFT → DONE, after 40 bits.
  - DONE → IDLE, after 1 cycle.
- **Accept:** addr latched, shift register loaded with {READ_CMD, 8'h00 ⊕ zero-extended addr (24 bits), 8'h00}. Total 40 bits, sent MSB first.
- **SHIFT, per bit:**
  - `spi_sclk` low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - `spi_mosi` changes only while sclk is low, at the start of the bit.
  - `spi_miso` is sampled on the clk edge that drives sclk high.
- **MOSI content:** bits 39..8 carry cmd+addr; bits 7..0 drive `spi_mosi`=0. MISO samples during bits 7..0 form the data byte, MSB first.
- **DONE:**
  - `spi_cs_n`=1, `spi_sclk`=0.
  - `rdata` is updated with the data byte.
  - `ready`=1 for exactly this cycle; `busy`=0.
- Requests while `busy`=1 are ignored, not queued. The core must hold `req` until `ready`.
- `req` may be asserted during DONE. It is accepted on the following edge, which guarantees at least one cycle of CS high between transfers.
- Bit counter: 6 bits, counts 39 down to 0. Divider counter: wide enough for CLK_DIV-1 and wraps to 0 at each sclk toggle.

## Timing
- **Reset (async, immediate):**
  - `spi_cs_n`=1, `spi_sclk`=0, `spi_mosi`=0.
  - `ready`=0, `busy`=0, `rdata`=8'h00, state IDLE.
- **Reset mid-transfer:** aborts with no `ready` pulse. CS rises asynchronously with reset assertion.
- **Accepting edge E0:**
  - `busy`=1, `spi_cs_n`=0, `spi_mosi`=READ_CMD[7].
  - First sclk rise at E0+CLK_DIV.
- **Latency:** `ready` is asserted in the cycle following edge E0+80·CLK_DIV. That is 160 cycles at CLK_DIV=2.
- **sclk fall:** the last sclk fall coincides with entry to DONE.
- **Back-to-back period:** 80·CLK_DIV+1 cycles per byte.

## Configuration
- Macro `SPI_ROM_CACHE_EN` enables a single-entry last-address cache.
- **When defined:**
  - Cache valid bit is cleared by `rst`.
  - If `req` is accepted with `addr` equal to the cached address and the cache is valid: the next cycle is DONE with the cached byte, there is no CS activity, and latency is 1 cycle.
  - Every completed SPI transfer refreshes the tag and data.
- **When undefined:** every request performs a full SPI transfer. No tag storage is synthesized.

## Test plan
1. **Single fetch.** After reset, `req` with addr=16'h1234 and a flash model returning 8'hA5 → MOSI stream is 03 00 12 34 00, `ready` at E0+160, `rdata`=8'hA5, CS high in DONE.
2. **Back-to-back.** `req` held high for addresses 0x0000 then 0x0001 with bytes 0x11, 0x22 → two `ready` pulses 161 cycles apart, CS high for exactly 1 cycle between transfers.
3. **Request while busy.** `req` pulse with addr 0xBEEF at E0+20 during a transfer → ignored, only one transfer, `rdata` from the original address.
4. **Reset mid-transfer.** Assert `rst` at E0+50 → `spi_cs_n`=1, `spi_sclk`=0, `busy`=0, `rdata`=0 immediately; no `ready` pulse; the next `req` starts a clean 03-command.
5. **Cache hit.** With `SPI_ROM_CACHE_EN`, repeat addr 0x1234 → `ready` one cycle after accept, `rdata`=8'hA5, CS stays high. Without the macro, the same stimulus performs a full 160-cycle transfer.
6. **Divider check.** CLK_DIV=1, addr 0xFFFF → `spi_sclk` period is 2 cycles, latency 80 cycles, MOSI address bytes 00 FF FF.
